// File: rtl/bus16_ram_responder.sv
// Memory target for the 16-bit byte/halfword bus: a halfword-wide RAM split into
// two byte lanes, a programmable wait-state delay and a single-cycle ack per transfer.
module bus16_ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] s_adr_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic        s_siz_i,
  input  logic        s_signed_i,
  input  logic [15:0] s_dat_i,
  output logic        s_ack_o,
  output logic [15:0] s_dat_o
);

  localparam int DEPTH = 1 << (ADDR_BITS - 1);
  localparam int IW    = ADDR_BITS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state;
  logic [3:0] wait_cnt;

  logic [IW-1:0] req_idx;
  logic          req_lane;
  logic          req_we;
  logic          req_siz;
  logic          req_signed;
  logic [15:0]   req_dat;

  logic [7:0] ram_lo [DEPTH];
  logic [7:0] ram_hi [DEPTH];

  logic          from_idle;
  logic          from_wait;
  logic          commit;
  logic [IW-1:0] acc_idx;
  logic          acc_lane;
  logic          acc_we;
  logic          acc_siz;
  logic          acc_signed;
  logic [15:0]   acc_dat;
  logic [7:0]    rd_lo;
  logic [7:0]    rd_hi;
  logic [7:0]    byte_sel;
  logic [15:0]   rd_data;

  logic unused_adr;
  assign unused_adr = ^s_adr_i[63:ADDR_BITS];

  // The access commits on the edge that enters ACK; with no wait states that is
  // the capture edge itself, so the live bus fields are used instead of the registers.
  always_comb begin
    from_idle = (state == S_IDLE) && s_cyc_i && s_stb_i && (WAIT_STATES == 0);
    from_wait = (state == S_WAIT) && s_cyc_i && (wait_cnt == 4'd1);
    commit    = from_idle || from_wait;
    if (from_idle) begin
      acc_idx    = s_adr_i[ADDR_BITS-1:1];
      acc_lane   = s_adr_i[0];
      acc_we     = s_we_i;
      acc_siz    = s_siz_i;
      acc_signed = s_signed_i;
      acc_dat    = s_dat_i;
    end else begin
      acc_idx    = req_idx;
      acc_lane   = req_lane;
      acc_we     = req_we;
      acc_siz    = req_siz;
      acc_signed = req_signed;
      acc_dat    = req_dat;
    end
  end

  always_comb begin
    rd_lo    = ram_lo[acc_idx];
    rd_hi    = ram_hi[acc_idx];
    byte_sel = acc_lane ? rd_hi : rd_lo;
    if (acc_siz) begin
      rd_data = {rd_hi, rd_lo};
    end else if (acc_signed) begin
      rd_data = {{8{byte_sel[7]}}, byte_sel};
    end else begin
      rd_data = {8'h00, byte_sel};
    end
  end

  // RAM contents survive reset; a reset edge only suppresses the write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && acc_we) begin
      if (acc_siz) begin
        ram_lo[acc_idx] <= acc_dat[7:0];
        ram_hi[acc_idx] <= acc_dat[15:8];
      end else if (acc_lane) begin
        ram_hi[acc_idx] <= acc_dat[7:0];
      end else begin
        ram_lo[acc_idx] <= acc_dat[7:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      s_ack_o  <= 1'b0;
      s_dat_o  <= 16'h0000;
    end else begin
      s_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_cyc_i && s_stb_i) begin
            req_idx    <= s_adr_i[ADDR_BITS-1:1];
            req_lane   <= s_adr_i[0];
            req_we     <= s_we_i;
            req_siz    <= s_siz_i;
            req_signed <= s_signed_i;
            req_dat    <= s_dat_i;
            wait_cnt   <= 4'(WAIT_STATES);
            state      <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!s_cyc_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (commit) begin
        s_ack_o <= 1'b1;
        if (!acc_we) begin
          s_dat_o <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus16_ram_responder.sv
// Bench for bus16_ram_responder: two instances (0 and 3 wait states) checked against
// a byte-addressed memory model with directed scenarios and random transfers.
module tb_bus16_ram_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] adr;
  logic        cyc, stb, we, siz, sgn;
  logic [15:0] wdat;
  logic        sel;

  logic        cyc0, stb0, cyc3, stb3;
  logic        ack0, ack3, ack;
  logic [15:0] q0, q3, qmux;

  assign cyc0 = cyc & ~sel;
  assign stb0 = stb & ~sel;
  assign cyc3 = cyc & sel;
  assign stb3 = stb & sel;
  assign ack  = sel ? ack3 : ack0;
  assign qmux = sel ? q3 : q0;

  bus16_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .s_adr_i(adr), .s_cyc_i(cyc0), .s_stb_i(stb0),
    .s_we_i(we), .s_siz_i(siz), .s_signed_i(sgn), .s_dat_i(wdat),
    .s_ack_o(ack0), .s_dat_o(q0)
  );

  bus16_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .s_adr_i(adr), .s_cyc_i(cyc3), .s_stb_i(stb3),
    .s_we_i(we), .s_siz_i(siz), .s_signed_i(sgn), .s_dat_i(wdat),
    .s_ack_o(ack3), .s_dat_o(q3)
  );

  int tests = 0;
  int fails = 0;

  // Reference memory indexed by the 12-bit byte address, one per instance.
  logic [7:0]  mem [2][4096];
  logic [15:0] last_rd [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the target idle; returns at a negedge after the ack.
  task automatic xfer(input logic s, input logic w, input logic z, input logic g,
                      input logic [63:0] a, input logic [15:0] d, output logic [15:0] q);
    int ws;
    ws   = s ? 3 : 0;
    sel  = s;
    adr  = a;
    we   = w;
    siz  = z;
    sgn  = g;
    wdat = d;
    cyc  = 1'b1;
    stb  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb  = 1'b0;
    adr  = ~a;
    wdat = ~d;
    for (int k = 0; k < ws; k++) begin
      check("ack_early", {15'b0, ack}, 16'h0000);
      @(negedge clk);
    end
    check("ack_latency", {15'b0, ack}, 16'h0001);
    q   = qmux;
    cyc = 1'b0;
    @(negedge clk);
    check("ack_single", {15'b0, ack}, 16'h0000);
  endtask

  task automatic mwrite(input logic s, input logic z, input logic [63:0] a, input logic [15:0] d);
    logic [15:0] q;
    int si, i;
    si = int'(s);
    i  = int'(a[11:0]);
    xfer(s, 1'b1, z, 1'b0, a, d, q);
    check("hold_on_write", q, last_rd[si]);
    if (z) begin
      mem[si][i & ~1] = d[7:0];
      mem[si][i | 1]  = d[15:8];
    end else begin
      mem[si][i] = d[7:0];
    end
  endtask

  task automatic mread(input logic s, input logic z, input logic g, input logic [63:0] a,
                       output logic [15:0] q);
    logic [15:0] exp;
    logic [7:0]  b;
    int si, i;
    si = int'(s);
    i  = int'(a[11:0]);
    if (z) begin
      exp = {mem[si][i | 1], mem[si][i & ~1]};
    end else begin
      b   = mem[si][i];
      exp = g ? {{8{b[7]}}, b} : {8'h00, b};
    end
    xfer(s, 1'b0, z, g, a, 16'h0000, q);
    check("read_model", q, exp);
    last_rd[si] = exp;
  endtask

  initial begin
    logic [15:0] q;
    logic [63:0] a;
    int nacks;

    rst_n = 1'b0;
    sel = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; siz = 1'b0; sgn = 1'b0;
    adr = 64'h0; wdat = 16'h0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack0", {15'b0, ack0}, 16'h0000);
    check("reset_ack3", {15'b0, ack3}, 16'h0000);
    check("reset_dat0", q0, 16'h0000);
    check("reset_dat3", q3, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill a 64-byte window in both instances so reads are always defined.
    for (int s = 0; s < 2; s++)
      for (int h = 0; h < 32; h++)
        mwrite(s[0], 1'b1, 64'(h * 2), 16'($urandom()));

    // Directed halfword/byte sequence on the zero-wait instance.
    mwrite(1'b0, 1'b1, 64'h10, 16'hBEEF);
    mread(1'b0, 1'b1, 1'b0, 64'h10, q);
    check("rd_beef", q, 16'hBEEF);
    mwrite(1'b0, 1'b0, 64'h11, 16'hAA12);
    mread(1'b0, 1'b0, 1'b0, 64'h11, q);
    check("rd_byte_12", q, 16'h0012);
    mread(1'b0, 1'b1, 1'b0, 64'h10, q);
    check("rd_12ef", q, 16'h12EF);
    mread(1'b0, 1'b0, 1'b1, 64'h10, q);
    check("rd_signed_ef", q, 16'hFFEF);
    mread(1'b0, 1'b0, 1'b0, 64'h10, q);
    check("rd_unsigned_ef", q, 16'h00EF);
    mread(1'b0, 1'b1, 1'b0, 64'h11, q);
    check("rd_half_odd_adr", q, 16'h12EF);

    // Held strobe through an aliased address: acks on alternate cycles.
    sel = 1'b0; adr = 64'h1010; we = 1'b0; siz = 1'b1; sgn = 1'b0;
    cyc = 1'b1; stb = 1'b1;
    nacks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("held_ack", {15'b0, ack}, (k % 2 == 0) ? 16'h0001 : 16'h0000);
      if (ack) begin
        nacks++;
        check("held_alias_data", q0, 16'h12EF);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    last_rd[0] = 16'h12EF;
    check("held_count", 16'(nacks), 16'd3);
    @(negedge clk);

    // Three wait states: latency is checked inside xfer.
    mwrite(1'b1, 1'b1, 64'h10, 16'h1234);
    mread(1'b1, 1'b1, 1'b0, 64'h10, q);
    check("ws3_rd", q, 16'h1234);

    // Abort: cyc dropped two edges after capture.
    sel = 1'b1; adr = 64'h10; we = 1'b1; siz = 1'b1; sgn = 1'b0; wdat = 16'h7777;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    check("abort_ack_a", {15'b0, ack}, 16'h0000);
    @(negedge clk);
    check("abort_ack_b", {15'b0, ack}, 16'h0000);
    cyc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_ack", {15'b0, ack}, 16'h0000);
    end
    mread(1'b1, 1'b1, 1'b0, 64'h10, q);
    check("abort_ram_kept", q, 16'h1234);

    // Reset on the edge that would enter ACK of a write.
    mwrite(1'b1, 1'b1, 64'h20, 16'hA0A0);
    mread(1'b1, 1'b1, 1'b0, 64'h20, q);
    sel = 1'b1; adr = 64'h20; we = 1'b1; siz = 1'b1; sgn = 1'b0; wdat = 16'h5555;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    check("rst_pre_ack_a", {15'b0, ack}, 16'h0000);
    @(negedge clk);
    check("rst_pre_ack_b", {15'b0, ack}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_no_ack", {15'b0, ack}, 16'h0000);
    check("rst_dat_clear", q3, 16'h0000);
    rst_n = 1'b1;
    cyc = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    mread(1'b1, 1'b1, 1'b0, 64'h20, q);
    check("rst_old_data", q, 16'hA0A0);

    // Random transfers inside the window, upper address bits random to exercise aliasing.
    for (int n = 0; n < 80; n++) begin
      a = {$urandom(), $urandom()};
      a[11:6] = 6'd0;
      if ($urandom_range(0, 1) == 1)
        mwrite($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, 16'($urandom()));
      else
        mread($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, a, q);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus16_ram_responder.md
Name: bus16_ram_responder

Overview:
- Responder (target) for the narrow 16-bit byte/halfword bus produced by the 64-to-16 bus bottleneck.
- Holds a synchronous RAM of 2^(ADDR_BITS-1) halfwords and serves byte and halfword reads and writes.
- Has a programmable wait-state count and issues a single-cycle ack per transfer.
- Sits directly on the bottleneck's s_* side as the terminating memory/target model for the 16-bit bus.

Parameters:
- ADDR_BITS, 12, number of byte-address bits decoded; RAM depth is 2^(ADDR_BITS-1) halfwords; higher address bits are ignored, so the RAM aliases.
- WAIT_STATES, 0, extra cycles inserted between request capture and ack; legal range 0..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- s_adr_i  in  64  byte address; only [ADDR_BITS-1:0] are used.
- s_cyc_i  in  1  bus cycle active.
- s_stb_i  in  1  transfer strobe.
- s_we_i  in  1  1 = write, 0 = read.
- s_siz_i  in  1  0 = byte, 1 = halfword.
- s_signed_i  in  1  selects sign-extension of byte reads into s_dat_o[15:8].
- s_dat_i  in  16  write data; a byte write uses [7:0], a halfword write uses [15:0].
- s_ack_o  out  1  one-cycle transfer acknowledge.
- s_dat_o  out  16  read data; valid in the s_ack_o cycle of a read.

Behaviour:
- Reset, sampled at an edge with rst_ni=0:
  - State goes to IDLE, wait counter to 0, s_ack_o to 0, s_dat_o to 16'h0000.
  - No RAM write occurs in that cycle.
  - RAM contents are not reset.
- State machine IDLE -> WAIT -> ACK -> IDLE:
  - IDLE: when s_cyc_i & s_stb_i, register the address bits, we, siz, signed and s_dat_i. Load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise ACK.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to ACK.
  - ACK: s_ack_o=1 for exactly this cycle. The RAM access (read or write) commits in this cycle. Next state is IDLE.
- Latency: a strobe sampled at edge N gives s_ack_o high during cycle N+1+WAIT_STATES.
- IDLE does not sample the strobe in the cycle it is re-entered from ACK. A strobe held high therefore produces one ack every 2+WAIT_STATES cycles, each counted as a new transfer.
- Abort: if s_cyc_i=0 at any edge while in WAIT, return to IDLE with no ack and no write. In ACK the transfer completes regardless.
- Inputs are captured at request time. Changes to s_adr_i or s_dat_i during WAIT have no effect.
- Addressing is little-endian: halfword index = adr[ADDR_BITS-1:1]; adr[0]=0 selects bits [7:0], adr[0]=1 selects bits [15:8].
- Halfword access ignores adr[0] and always accesses the aligned halfword.
- Byte write updates only the selected byte lane with s_dat_i[7:0]; the other lane is unchanged.
- Halfword write stores s_dat_i[15:0].
- Byte read:
  - s_dat_o[7:0] = selected byte.
  - s_dat_o[15:8] = {8{byte[7]}} if signed=1, else 8'h00.
- Halfword read: s_dat_o = stored halfword; the signed flag is ignored.
- s_dat_o updates only at the edge entering a read ACK and holds its value otherwise, including across write acks.
- Read-after-write to the same address in consecutive transfers returns the newly written data.
- A reset asserted during WAIT or ACK cancels the transfer: no ack and no write at that edge.

Test Plan:
- Write halfword 16'hBEEF at adr 0x10, then read halfword at 0x10 (WAIT_STATES=0) -> each ack appears exactly 1 cycle after strobe capture; read returns 16'hBEEF.
- After the above, byte write 8'h12 at 0x11, then unsigned byte read at 0x11 -> 16'h0012; halfword read at 0x10 -> 16'h12EF.
- Signed byte read of 0x10 holding 8'hEF -> 16'hFFEF; same read unsigned -> 16'h00EF.
- WAIT_STATES=3: strobe captured at edge N -> ack in cycle N+4 only. Drop s_cyc_i at edge N+2 in a second write -> no ack, RAM unchanged.
- Strobe held high for 6 cycles with WAIT_STATES=0 -> acks in alternate cycles, three transfers. Address 0x1010 with ADDR_BITS=12 aliases 0x0010.
- Assert rst_ni=0 for one edge in the ACK cycle of a write of 16'h5555 to 0x20 -> no ack, s_dat_o=16'h0000, and a subsequent read of 0x20 returns the old contents.
